bf2i_bundle_serializer: RTL and testbench
=========================================

BF2I_BUNDLE_SERIALIZER -- requirements
Module: bf2i_bundle_serializer

Interface
REQ-001 Parameter WIDTH, default 9, output sample width; input samples are WIDTH+1 bits (butterfly growth).
REQ-002 Parameter DEPTH, default 16, samples per input bundle.
REQ-003 Parameter OFFSET, default 8, butterfly pair distance; used only for pair-interleaved order.
REQ-004 Parameter ORDER, default 0: 0 selects natural order, 1 selects pair-interleaved order.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 en  input  1  global enable; 0 freezes all state.
REQ-009 in_valid  input  1  bundle on din_R/din_Q is valid.
REQ-010 in_ready  output  1  block accepts a bundle this cycle.
REQ-011 din_R  input  DEPTH x (WIDTH+1) signed  butterfly real outputs.
REQ-012 din_Q  input  DEPTH x (WIDTH+1) signed  butterfly imaginary outputs.
REQ-013 out_valid  output  1  dout_R/dout_Q/out_idx/out_last are valid.
REQ-014 out_ready  input  1  downstream accepts the sample.
REQ-015 dout_R, dout_Q  output  WIDTH signed each  scaled sample.
REQ-016 out_idx  output  clog2(DEPTH)  bundle index of the current sample.
REQ-017 out_last  output  1  current sample is the last of its bundle.

Function
REQ-018 Input transfer = in_valid & in_ready & en; output transfer = out_valid & out_ready & en.
REQ-019 FSM states EMPTY and SEND; EMPTY->SEND on input transfer; SEND->EMPTY on output transfer of the last sample with no simultaneous input transfer; SEND->SEND otherwise.
REQ-020 in_ready SHALL be en & (EMPTY | (SEND & out_last & out_ready)); combinational from out_ready, no other path.
REQ-021 An input transfer SHALL capture all 2*DEPTH samples into the bundle buffer and reset the sample counter to 0.
REQ-022 Latency: bundle captured at edge N -> first sample has out_valid=1 in the cycle after edge N.
REQ-023 Each output transfer SHALL advance the counter by 1; counter DEPTH-1 asserts out_last.
REQ-024 Back-to-back bundles SHALL stream with no bubble: DEPTH output transfers per DEPTH cycles when out_ready=1.
REQ-025 ORDER=0: out_idx = counter; ORDER=1: out_idx sequence 0,OFFSET,1,OFFSET+1,...,OFFSET-1,DEPTH-1.
REQ-026 Scaling per component: y = (x + 1) >>> 1 (round half up), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 WIDTH=9 boundaries: 511->255 (saturated), 510->255, -512->-256, -511->-255, 1->1, -1->0.
REQ-028 While out_valid=1 and no output transfer, all outputs SHALL hold stable.
REQ-029 en=0: state, counter, buffer and outputs SHALL hold; in_ready=0; no transfers occur.
REQ-030 in_valid while in SEND and not at the last-sample transfer SHALL be ignored (in_ready=0).

Reset
REQ-031 rst_n=0 at an edge SHALL force state EMPTY, counter 0, out_valid 0, out_last 0, out_idx 0, dout_R 0, dout_Q 0, regardless of en.
REQ-032 Reset mid-bundle SHALL discard remaining samples; first cycle after release in_ready = en.
REQ-033 Bundle buffer contents need not be reset.

Structure
REQ-034 Shared package fft_pkg SHALL hold WIDTH/DEPTH/OFFSET defaults, the FSM state enum, and the index-map function for ORDER.
REQ-035 One sub-module, fft_round_sat, SHALL implement REQ-026 for one component; instantiated twice (R, Q) on the selected sample.
REQ-036 Outputs SHALL be registered; only in_ready is combinational.

Verification
REQ-037 Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, dout=0, in_ready=1 after release with en=1.
REQ-038 Single bundle, ORDER=0: din_R[i]=2*i, din_Q[i]=-2*i, out_ready=1 -> 16 samples dout_R=i, dout_Q=-i, out_last only at idx 15.
REQ-039 Saturation/rounding: din_R[0..5]={511,510,-512,-511,1,-1} -> dout_R={255,255,-256,-255,1,0}.
REQ-040 Backpressure: out_ready toggled 1,0,0,1 per cycle -> outputs stable during stalls, no sample lost or duplicated, in order.
REQ-041 Back-to-back: two bundles with in_valid held 1 -> 32 consecutive transfers, in_ready pulses once at idx 15 of bundle 1.
REQ-042 en=0 for 3 cycles mid-bundle (idx 5), ORDER=1 -> outputs frozen at idx 10, resume with idx 3 after en=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the butterfly bundle serializer.
//   - default WIDTH / DEPTH / OFFSET
//   - FSM state type of the serializer
//   - idx_map(): counter -> buffer index for the selected output order
package fft_pkg;

    localparam int WIDTH_DEF  = 9;
    localparam int DEPTH_DEF  = 16;
    localparam int OFFSET_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    // order 0: natural; order 1: butterfly pairs (k, k+OFFSET) back to back,
    // so even counts walk the lower half and odd counts the upper half.
    function automatic int idx_map(input int order, input int offset, input int k);
        if (order == 0) begin
            return k;
        end
        return ((k % 2) == 0) ? (k / 2) : (offset + k / 2);
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Scales one butterfly component by 1/2 with round-half-up, then saturates.
//   x : WIDTH+1 bit signed butterfly output
//   y : WIDTH bit signed scaled sample
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH:0]   x,
    output logic signed [WIDTH-1:0] y
);

    localparam logic signed [WIDTH:0] MAXV = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] MINV = {2'b11, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [WIDTH:0] v);
        logic signed [WIDTH+1:0] sum;
        logic signed [WIDTH:0]   half;
        // One guard bit so +1 cannot wrap at the positive full-scale input.
        sum  = {v[WIDTH], v} + {{(WIDTH+1){1'b0}}, 1'b1};
        half = sum[WIDTH+1:1];
        if (half > MAXV) begin
            return MAXV[WIDTH-1:0];
        end else if (half < MINV) begin
            return MINV[WIDTH-1:0];
        end
        return half[WIDTH-1:0];
    endfunction

    assign y = round_sat(x);

endmodule

// File: rtl/bf2i_bundle_serializer.sv
// Captures a DEPTH-sample butterfly bundle (real + imaginary) in one transfer
// and streams it out one scaled sample per output handshake.
//   clk, rst_n         : clock, synchronous active-low reset
//   en                 : global enable, 0 freezes everything
//   in_valid/in_ready  : bundle handshake on din_R/din_Q (WIDTH+1 bits each)
//   out_valid/out_ready: sample handshake on dout_R/dout_Q (WIDTH bits each)
//   out_idx            : bundle index of the presented sample
//   out_last           : presented sample is the last of its bundle
module bf2i_bundle_serializer
    import fft_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int OFFSET = OFFSET_DEF,
    parameter int ORDER  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH:0]      din_R [DEPTH],
    input  logic signed [WIDTH:0]      din_Q [DEPTH],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    dout_R,
    output logic signed [WIDTH-1:0]    dout_Q,
    output logic [$clog2(DEPTH)-1:0]   out_idx,
    output logic                       out_last
);

    localparam int             IW       = $clog2(DEPTH);
    localparam logic [IW-1:0]  LAST_CNT = IW'(DEPTH - 1);

    state_t                 state, state_nxt;
    logic [IW-1:0]          cnt, cnt_nxt, idx_nxt;
    logic signed [WIDTH:0]  buf_r [DEPTH];
    logic signed [WIDTH:0]  buf_q [DEPTH];
    logic signed [WIDTH:0]  sel_r, sel_q;
    logic signed [WIDTH-1:0] sc_r, sc_q;
    logic                   in_xfer, out_xfer;

    // A new bundle is only taken when the buffer is free or is being freed
    // by the last-sample transfer in this very cycle (no bubble between bundles).
    assign in_ready = en & ((state == EMPTY) | ((state == SEND) & out_last & out_ready));
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready & en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (in_xfer) state_nxt = SEND;
            SEND:    if (out_xfer && out_last && !in_xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Select the sample that will be presented after this edge. On capture it
    // comes straight from din so the first sample is valid one cycle later.
    always_comb begin
        cnt_nxt = in_xfer ? '0 : cnt + 1'b1;
        idx_nxt = IW'(idx_map(ORDER, OFFSET, int'(cnt_nxt)));
        sel_r   = in_xfer ? din_R[idx_nxt] : buf_r[idx_nxt];
        sel_q   = in_xfer ? din_Q[idx_nxt] : buf_q[idx_nxt];
    end

    fft_round_sat #(.WIDTH(WIDTH)) u_rs_r (.x(sel_r), .y(sc_r));
    fft_round_sat #(.WIDTH(WIDTH)) u_rs_q (.x(sel_q), .y(sc_q));

    // Bundle buffer: data only, never reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            buf_r <= din_R;
            buf_q <= din_Q;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            dout_R    <= '0;
            dout_Q    <= '0;
        end else if (in_xfer || (out_xfer && !out_last)) begin
            cnt       <= cnt_nxt;
            out_valid <= 1'b1;
            out_last  <= (cnt_nxt == LAST_CNT);
            out_idx   <= idx_nxt;
            dout_R    <= sc_r;
            dout_Q    <= sc_q;
        end else if (out_xfer) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf2i_bundle_serializer.sv
module tb_bf2i_bundle_serializer;

    localparam int W   = 9;
    localparam int D   = 16;
    localparam int OFF = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [W:0] din_R [D];
    logic signed [W:0] din_Q [D];

    logic              ir [2];
    logic              ov [2];
    logic              ol [2];
    logic [3:0]        ix [2];
    logic signed [W-1:0] dr [2];
    logic signed [W-1:0] dq [2];

    bf2i_bundle_serializer #(.WIDTH(W), .DEPTH(D), .OFFSET(OFF), .ORDER(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir[0]),
        .din_R(din_R), .din_Q(din_Q), .out_valid(ov[0]), .out_ready(out_ready),
        .dout_R(dr[0]), .dout_Q(dq[0]), .out_idx(ix[0]), .out_last(ol[0]));

    bf2i_bundle_serializer #(.WIDTH(W), .DEPTH(D), .OFFSET(OFF), .ORDER(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir[1]),
        .din_R(din_R), .din_Q(din_Q), .out_valid(ov[1]), .out_ready(out_ready),
        .dout_R(dr[1]), .dout_Q(dq[1]), .out_idx(ix[1]), .out_last(ol[1]));

    always #5 clk = ~clk;

    typedef struct {
        int idx0; int r0; int q0;
        int idx1; int r1; int q1;
        bit last;
    } exp_t;

    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;
    int   ord1 [D];
    int   cyc_n = 0;
    int   ncyc = 0;
    int   or_mode = 0;
    int   b2b_accepts = 0;
    int   xfers = 0;
    int   first_x = -1;
    int   last_x = -1;
    bit   stall_prev = 0;
    int   sv_ix [2];
    int   sv_r [2];
    int   sv_q [2];
    bit   sv_l [2];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Halve with round-half-up (floor of (x+1)/2), then clamp to WIDTH bits.
    function automatic int scale(input int x);
        int t, y;
        t = x + 1;
        y = (t >= 0) ? (t / 2) : -((1 - t) / 2);
        if (y > (1 << (W - 1)) - 1) y = (1 << (W - 1)) - 1;
        if (y < -(1 << (W - 1)))    y = -(1 << (W - 1));
        return y;
    endfunction

    // Scoreboard producer: every accepted bundle becomes D expected samples.
    always @(negedge clk) begin
        if (rst_n && en && in_valid && ir[0]) begin
            if (ov[0]) b2b_accepts++;
            for (int k = 0; k < D; k++) begin
                exp_t e;
                e.idx0 = k;
                e.r0   = scale(int'(din_R[k]));
                e.q0   = scale(int'(din_Q[k]));
                e.idx1 = ord1[k];
                e.r1   = scale(int'(din_R[ord1[k]]));
                e.q1   = scale(int'(din_Q[ord1[k]]));
                e.last = (k == D - 1);
                sb.push_back(e);
            end
        end
    end

    // Monitor: compares every output transfer and checks hold during stalls.
    always @(negedge clk) begin
        ncyc++;
        if (rst_n) begin
            if (stall_prev) begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("u%0d_hold_valid", d), int'(ov[d]), 1);
                    check($sformatf("u%0d_hold_idx", d), int'(ix[d]), sv_ix[d]);
                    check($sformatf("u%0d_hold_R", d), int'(dr[d]), sv_r[d]);
                    check($sformatf("u%0d_hold_Q", d), int'(dq[d]), sv_q[d]);
                    check($sformatf("u%0d_hold_last", d), int'(ol[d]), int'(sv_l[d]));
                end
            end
            for (int d = 0; d < 2; d++) begin
                check($sformatf("u%0d_in_ready", d), int'(ir[d]),
                      int'(en && (!ov[d] || (ol[d] && out_ready))));
            end
            check("u1_valid_align", int'(ov[1]), int'(ov[0]));
            if (ov[0] && out_ready && en) begin
                if (sb.size() == 0) begin
                    check("unexpected_output_pending", 0, 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("u0_idx", int'(ix[0]), e.idx0);
                    check("u0_R", int'(dr[0]), e.r0);
                    check("u0_Q", int'(dq[0]), e.q0);
                    check("u0_last", int'(ol[0]), int'(e.last));
                    check("u1_idx", int'(ix[1]), e.idx1);
                    check("u1_R", int'(dr[1]), e.r1);
                    check("u1_Q", int'(dq[1]), e.q1);
                    check("u1_last", int'(ol[1]), int'(e.last));
                end
                xfers++;
                if (first_x < 0) first_x = ncyc;
                last_x = ncyc;
            end
        end
        stall_prev = rst_n && ov[0] && !(out_ready && en);
        for (int d = 0; d < 2; d++) begin
            sv_ix[d] = int'(ix[d]);
            sv_r[d]  = int'(dr[d]);
            sv_q[d]  = int'(dq[d]);
            sv_l[d]  = ol[d];
        end
    end

    // One clock; out_ready (and en in random mode) follow the current mode.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((cyc_n % 4) == 0) || ((cyc_n % 4) == 3);
            default: begin
                out_ready = ($urandom_range(0, 3) != 0);
                en        = ($urandom_range(0, 7) != 0);
            end
        endcase
        #1;
    endtask

    task automatic load_bundle(input int kind);
        int sat_tab [6];
        sat_tab = '{511, 510, -512, -511, 1, -1};
        for (int i = 0; i < D; i++) begin
            case (kind)
                0: begin
                    din_R[i] = 10'(2 * i);
                    din_Q[i] = 10'(-2 * i);
                end
                1: begin
                    din_R[i] = (i < 6) ? 10'(sat_tab[i]) : 10'($urandom_range(0, 1023));
                    din_Q[i] = 10'($urandom_range(0, 1023));
                end
                default: begin
                    din_R[i] = 10'($urandom_range(0, 1023));
                    din_Q[i] = 10'($urandom_range(0, 1023));
                end
            endcase
        end
    endtask

    task automatic send(input int kind);
        load_bundle(kind);
        in_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (ir[0]) begin
                cyc();
                in_valid = 1'b0;
                return;
            end
            cyc();
        end
        check("send_timeout_ready", int'(ir[0]), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 1000; c++) begin
            if (sb.size() == 0 && !ov[0]) return;
            cyc();
        end
        check("drain_timeout_pending", sb.size(), 0);
    endtask

    initial begin
        int n;
        bit found;
        n = 0;
        for (int j = 0; j < OFF; j++) begin
            ord1[n] = j;       n++;
            ord1[n] = j + OFF; n++;
        end

        // Reset held for two edges with in_valid asserted.
        load_bundle(2);
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; or_mode = 0;
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("u%0d_rst_valid", d), int'(ov[d]), 0);
            check($sformatf("u%0d_rst_R", d), int'(dr[d]), 0);
            check($sformatf("u%0d_rst_Q", d), int'(dq[d]), 0);
            check($sformatf("u%0d_rst_idx", d), int'(ix[d]), 0);
            check($sformatf("u%0d_rst_last", d), int'(ol[d]), 0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_release_in_ready", int'(ir[0]), 1);

        // Ramp bundle, natural order: R = i, Q = -i.
        send(0);
        drain();

        // Rounding and saturation boundaries.
        send(1);
        drain();

        // Backpressure pattern 1,0,0,1.
        or_mode = 1;
        send(2);
        drain();
        send(0);
        drain();

        // Back-to-back bundles, in_valid held.
        or_mode = 0;
        b2b_accepts = 0; xfers = 0; first_x = -1;
        send(2);
        send(2);
        drain();
        check("b2b_accepts_while_busy", b2b_accepts, 1);
        check("b2b_transfers", xfers, 32);
        check("b2b_span", last_x - first_x, 31);

        // Enable freeze at counter 5 (pair order shows index 10).
        send(0);
        found = 0;
        for (int c = 0; c < 60; c++) begin
            if (ov[0] && ix[0] == 4'd5) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("freeze_reached_idx5", int'(found), 1);
        en = 1'b0;
        repeat (3) begin
            cyc();
            check("freeze_u1_idx", int'(ix[1]), 10);
            check("freeze_u0_idx", int'(ix[0]), 5);
            check("freeze_in_ready", int'(ir[0]), 0);
        end
        en = 1'b1;
        drain();

        // Reset in the middle of a bundle discards the rest.
        send(2);
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        sb.delete();
        check("midrst_valid", int'(ov[0]), 0);
        check("midrst_idx", int'(ix[1]), 0);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_en1", int'(ir[0]), 1);
        en = 1'b0;
        #1;
        check("midrst_in_ready_en0", int'(ir[0]), 0);
        en = 1'b1;
        cyc();
        check("midrst_idle_valid", int'(ov[0]), 0);

        // Randomized traffic with random backpressure, enable and gaps.
        for (int b = 0; b < 20; b++) begin
            or_mode = 2;
            send($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) cyc();
        end
        or_mode = 0;
        en = 1'b1;
        drain();
        check("final_queue_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        checks++;
        $display("FAIL watchdog_time actual=%0d required=%0d", cyc_n, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
